// File: rtl/bytes_to_bridge_pkg.sv
// Shared definitions for the bridge read path: FSM states and word geometry.
package bytes_to_bridge_pkg;

    // Read sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bytes assembled into one bridge word.
    localparam int BYTES_PER_WORD = 4;

endpackage : bytes_to_bridge_pkg

// File: rtl/bytes_to_bridge.sv
// Services 32-bit bridge reads by issuing four sequential byte reads to a
// fixed-latency byte-wide memory and returning the big-endian assembled word.
//
// Handshake: br_rd is a one-cycle strobe with no ready; a request arriving
// while busy is parked in a one-deep pending slot, and a request arriving with
// that slot full is dropped and latches the sticky overflow flag.
module bytes_to_bridge
    import bytes_to_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 25,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  br_rd,
    input  logic [31:0]           br_addr,
    output logic [31:0]           br_rd_data,
    output logic                  br_rd_valid,
    output logic                  busy,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rd_data
);

    localparam int             BW  = ADDR_WIDTH - 2;
    localparam logic [3:0]     LAT = 4'(RD_LATENCY);
    localparam logic [1:0]     LAST_IDX = 2'(BYTES_PER_WORD - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   base_q, base_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [23:0]     word_q, word_d;
    logic [31:0]     br_rd_data_q, br_rd_data_d;
    logic            br_rd_valid_q, br_rd_valid_d;
    logic            mem_rd_q, mem_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic            overflow_q, overflow_d;
    logic            pend_v_q, pend_v_d;
    logic [BW-1:0]   pend_base_q, pend_base_d;

    logic [BW-1:0]   req_base;
    logic            unused_addr_bits;

    assign req_base         = br_addr[ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^{br_addr[31:ADDR_WIDTH], br_addr[1:0]};

    // Next-state, pending-slot and output computation for the read sequencer.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        br_rd_data_d  = br_rd_data_q;
        br_rd_valid_d = 1'b0;
        mem_rd_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        overflow_d    = overflow_q;
        pend_v_d      = pend_v_q;
        pend_base_d   = pend_base_q;

        case (state_q)
            IDLE: begin
                if (br_rd) begin
                    base_d     = req_base;
                    idx_d      = 2'd0;
                    state_d    = ISSUE;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {req_base, 2'd0};
                end
            end

            ISSUE: begin
                cnt_d   = 4'd1;
                state_d = WAIT;
                if (br_rd) begin
                    if (!pend_v_q) begin
                        pend_v_d    = 1'b1;
                        pend_base_d = req_base;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (br_rd) begin
                    if (!pend_v_q) begin
                        pend_v_d    = 1'b1;
                        pend_base_d = req_base;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (cnt_q == LAT) begin
                    if (idx_q == LAST_IDX) begin
                        // Last byte goes straight into the output word.
                        br_rd_data_d  = {word_q, mem_rd_data};
                        br_rd_valid_d = 1'b1;
                        state_d       = DONE;
                    end else begin
                        case (idx_q)
                            2'd0:    word_d[23:16] = mem_rd_data;
                            2'd1:    word_d[15:8]  = mem_rd_data;
                            default: word_d[7:0]   = mem_rd_data;
                        endcase
                        idx_d      = idx_q + 2'd1;
                        state_d    = ISSUE;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {base_q, idx_q + 2'd1};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                if (pend_v_q) begin
                    // A full slot is being drained this cycle, so a new strobe is lost.
                    if (br_rd) begin
                        overflow_d = 1'b1;
                    end
                    pend_v_d   = 1'b0;
                    base_d     = pend_base_q;
                    idx_d      = 2'd0;
                    state_d    = ISSUE;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {pend_base_q, 2'd0};
                end else if (br_rd) begin
                    base_d     = req_base;
                    idx_d      = 2'd0;
                    state_d    = ISSUE;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {req_base, 2'd0};
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // All state and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            idx_q         <= 2'd0;
            cnt_q         <= 4'd0;
            word_q        <= '0;
            br_rd_data_q  <= '0;
            br_rd_valid_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            overflow_q    <= 1'b0;
            pend_v_q      <= 1'b0;
            pend_base_q   <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            br_rd_data_q  <= br_rd_data_d;
            br_rd_valid_q <= br_rd_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            overflow_q    <= overflow_d;
            pend_v_q      <= pend_v_d;
            pend_base_q   <= pend_base_d;
        end
    end

    assign br_rd_data  = br_rd_data_q;
    assign br_rd_valid = br_rd_valid_q;
    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;

endmodule : bytes_to_bridge

// File: tb/tb_bytes_to_bridge.sv
// Bench for bytes_to_bridge: directed scenarios plus random traffic against a
// transaction-level model, with a second instance at RD_LATENCY=1.
module tb_bytes_to_bridge;

  localparam int L    = 2;
  localparam int LATW = 4 * (L + 1) + 1;

  logic clk = 1'b0;
  logic reset;

  logic        br_rd2, br_rd1;
  logic [31:0] br_addr2, br_addr1;
  logic [31:0] br_rd_data2, br_rd_data1;
  logic        br_rd_valid2, br_rd_valid1;
  logic        busy2, busy1, overflow2, overflow1;
  logic [24:0] mem_addr2, mem_addr1;
  logic        mem_rd2, mem_rd1;
  logic [7:0]  mem_rd_data2, mem_rd_data1;

  int checks = 0;
  int errors = 0;

  // clock
  always #5 clk = ~clk;

  bytes_to_bridge #(.ADDR_WIDTH(25), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .br_rd(br_rd2), .br_addr(br_addr2),
    .br_rd_data(br_rd_data2), .br_rd_valid(br_rd_valid2), .busy(busy2),
    .overflow(overflow2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
    .mem_rd_data(mem_rd_data2)
  );

  bytes_to_bridge #(.ADDR_WIDTH(25), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .br_rd(br_rd1), .br_addr(br_addr1),
    .br_rd_data(br_rd_data1), .br_rd_valid(br_rd_valid1), .busy(busy1),
    .overflow(overflow1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .mem_rd_data(mem_rd_data1)
  );

  // memory models: data = addr[7:0]^5A exactly RD_LATENCY cycles after mem_rd, EE otherwise
  logic        v2 [0:1];
  logic [24:0] a2 [0:1];
  logic        v1;
  logic [24:0] a1;

  always @(posedge clk) begin
    v2[0] <= mem_rd2;
    a2[0] <= mem_addr2;
    v2[1] <= v2[0];
    a2[1] <= a2[0];
    v1    <= mem_rd1;
    a1    <= mem_addr1;
  end

  assign mem_rd_data2 = v2[1] ? (a2[1][7:0] ^ 8'h5A) : 8'hEE;
  assign mem_rd_data1 = v1 ? (a1[7:0] ^ 8'h5A) : 8'hEE;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = {a[7:2], 2'(k)} ^ 8'h5A;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model state (transaction level)
  int          cyc = 0;
  bit          act = 0;
  int          done_c = 0;
  logic [31:0] cur_a = '0;
  bit          pv = 0;
  logic [31:0] pa = '0;
  bit          ovf = 0;
  logic [31:0] hold = '0;
  logic [24:0] last_ma = '0;
  // observations
  int          valid_count = 0;
  int          last_valid_cyc = -1;
  logic [31:0] last_valid_data = '0;

  // one cycle on the RD_LATENCY=2 instance: check outputs, drive inputs, advance model
  task automatic step(input logic rd, input logic [31:0] addr, input logic rst);
    logic        e_valid, e_mrd;
    logic [24:0] e_ma;
    int          off;
    @(negedge clk);
    e_valid = act && (cyc == done_c);
    off     = cyc - (done_c - LATW) - 1;
    e_mrd   = act && off >= 0 && (off % (L + 1)) == 0 && (off / (L + 1)) < 4;
    e_ma    = e_mrd ? {cur_a[24:2], 2'(off / (L + 1))} : last_ma;
    if (e_valid) hold = exp_word(cur_a);
    last_ma = e_ma;
    check("br_rd_valid", 32'(br_rd_valid2), 32'(e_valid));
    check("br_rd_data", br_rd_data2, hold);
    check("busy", 32'(busy2), 32'(act));
    check("mem_rd", 32'(mem_rd2), 32'(e_mrd));
    check("mem_addr", 32'(mem_addr2), 32'(e_ma));
    check("overflow", 32'(overflow2), 32'(ovf));
    if (br_rd_valid2 === 1'b1) begin
      valid_count++;
      last_valid_cyc  = cyc;
      last_valid_data = br_rd_data2;
    end
    br_rd2   = rd;
    br_addr2 = addr;
    reset    = rst;
    if (rst) begin
      act = 0; pv = 0; ovf = 0; hold = '0; last_ma = '0;
    end else if (act && cyc == done_c) begin
      if (pv) begin
        if (rd) ovf = 1;
        cur_a = pa; pv = 0; done_c = cyc + LATW;
      end else if (rd) begin
        cur_a = addr; done_c = cyc + LATW;
      end else begin
        act = 0;
      end
    end else if (act) begin
      if (rd) begin
        if (!pv) begin pv = 1; pa = addr; end
        else ovf = 1;
      end
    end else if (rd) begin
      act = 1; cur_a = addr; done_c = cyc + LATW;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int t, vc, v1_at, v1_cnt;
    logic [31:0] v1_data;
    bit rd;
    logic [31:0] ad;

    reset = 1'b1; br_rd2 = 1'b0; br_addr2 = '0; br_rd1 = 1'b0; br_addr1 = '0;
    repeat (2) @(posedge clk);
    idle(3);

    // single read of 0x100
    t = cyc; vc = valid_count;
    step(1'b1, 32'h0000_0100, 1'b0);
    idle(15);
    check("t1_latency", 32'(last_valid_cyc - t), 32'd13);
    check("t1_data", last_valid_data, 32'h5A5B_5859);
    check("t1_count", 32'(valid_count - vc), 32'd1);

    // ignored high and low address bits
    step(1'b1, 32'hF000_0103, 1'b0);
    idle(15);
    check("t2_data", last_valid_data, 32'h5A5B_5859);

    // queued second read chained through DONE
    t = cyc; vc = valid_count;
    step(1'b1, 32'h0000_0100, 1'b0);
    idle(4);
    step(1'b1, 32'h0000_0200, 1'b0);
    idle(24);
    check("t3_second_at", 32'(last_valid_cyc - t), 32'd26);
    check("t3_data", last_valid_data, 32'h5A5B_5859);
    check("t3_count", 32'(valid_count - vc), 32'd2);
    check("t3_overflow", 32'(overflow2), 32'd0);

    // three requests: third dropped
    vc = valid_count;
    step(1'b1, 32'h0000_0040, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0080, 1'b0);
    step(1'b1, 32'h0000_00C0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("t4_overflow", 32'(overflow2), 32'd1);
    idle(30);
    check("t4_count", 32'(valid_count - vc), 32'd2);

    // reset mid-read
    vc = valid_count;
    step(1'b1, 32'h0000_0300, 1'b0);
    idle(5);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("t5_busy", 32'(busy2), 32'd0);
    check("t5_mem_rd", 32'(mem_rd2), 32'd0);
    check("t5_overflow", 32'(overflow2), 32'd0);
    idle(20);
    check("t5_no_valid", 32'(valid_count - vc), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 5) == 0);
      ad = $urandom;
      step(rd, ad, ($urandom_range(0, 299) == 0));
    end
    idle(40);

    // RD_LATENCY=1 instance
    step(1'b0, 32'h0, 1'b0);
    br_rd1 = 1'b1; br_addr1 = 32'h0000_0010;
    v1_at = -1; v1_cnt = 0; v1_data = '0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 32'h0, 1'b0);
      br_rd1 = 1'b0;
      if (br_rd_valid1 === 1'b1) begin
        v1_cnt++;
        if (v1_at < 0) begin v1_at = n; v1_data = br_rd_data1; end
      end
    end
    check("lat1_at", 32'(v1_at), 32'd9);
    check("lat1_data", v1_data, 32'h4A4B_4849);
    check("lat1_count", 32'(v1_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bytes_to_bridge

// File: doc/bytes_to_bridge.md
Name: bytes_to_bridge

Overview:
- Read-side counterpart to the byte-write path that unpacks 32-bit bridge writes into sequential 8-bit memory writes.
- Services 32-bit bridge read requests (hiscore save, ROM/RAM readback) by issuing four sequential byte reads to a byte-wide, fixed-latency memory port.
- Assembles the four bytes big-endian and returns one 32-bit word with a valid pulse.
- Sits in the core clock domain, behind the bridge CDC, in front of core side RAMs.

Parameters:
- ADDR_WIDTH, 25, width of mem_addr.
- RD_LATENCY, 2, cycles from a mem_rd cycle to the cycle mem_rd_data is valid; legal range 1..15.

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- br_rd  in  1  single-cycle read request strobe.
- br_addr  in  32  request byte address, sampled when br_rd=1.
- br_rd_data  out  32  assembled word; valid when br_rd_valid=1, held until the next valid.
- br_rd_valid  out  1  one-cycle pulse per completed read.
- busy  out  1  high whenever state != IDLE.
- overflow  out  1  sticky; set when a request is dropped.
- mem_addr  out  ADDR_WIDTH  byte address to memory.
- mem_rd  out  1  one-cycle read strobe.
- mem_rd_data  in  8  read data, valid RD_LATENCY cycles after mem_rd.

Behaviour:
- Reset values (reset=1 at a clock edge):
  - State IDLE.
  - br_rd_data=0, br_rd_valid=0, busy=0, overflow=0, mem_rd=0, mem_addr=0.
  - Pending slot empty; byte index 0; latency counter 0.
- Reset has priority over every other event.
- Reset mid-operation aborts the read: no br_rd_valid, pending slot cleared, partial word discarded.
- Address mapping:
  - base = br_addr[ADDR_WIDTH-1:2], byte-aligned to 4.
  - br_addr[1:0] and bits above ADDR_WIDTH-1 are ignored.
  - mem_addr = {base, idx}, with idx = 0..3.
- Byte order: byte idx 0 goes to br_rd_data[31:24], idx 3 to [7:0].
- States:
  - IDLE: br_rd=1 latches base and sets idx=0; next state ISSUE.
  - ISSUE: one cycle. mem_rd=1, mem_addr={base,idx}; counter loaded with 1; next state WAIT.
  - WAIT: counter increments each cycle. In the cycle where counter==RD_LATENCY, mem_rd_data is captured into the lane for idx. Then:
    - if idx==3, next state DONE;
    - else idx++ and next state ISSUE.
  - DONE: one cycle. br_rd_valid=1 with the registered word. Next state:
    - ISSUE with the pending address if the pending slot is valid (slot cleared);
    - else ISSUE with br_addr if br_rd=1 this cycle;
    - else IDLE.
- Timing:
  - mem_rd is high only in ISSUE; mem_addr holds its value outside ISSUE.
  - Each byte takes RD_LATENCY+1 cycles.
  - br_rd accepted in IDLE at cycle T gives br_rd_valid at T+4·(RD_LATENCY+1)+1; for RD_LATENCY=2 that is T+13.
  - Back-to-back reads chained through DONE have no IDLE gap.
- Requests while busy:
  - br_rd in ISSUE or WAIT, or in DONE when the pending slot is full: stored in the one-deep pending slot if it is empty.
  - If the slot is full, the request is dropped and overflow is set.
  - overflow clears only on reset.
- br_rd_data changes only on the edge entering DONE.

Decomposition:
- Shared package (bridge package alongside pocket/athena): the state enum (IDLE, ISSUE, WAIT, DONE) and the BYTES_PER_WORD=4 constant.
- Single module; no sub-module needed. The pending slot and the lane register are inline.

Test Plan:
- Memory model returns mem[a] = a[7:0]^8'h5A at RD_LATENCY=2. br_rd with br_addr=0x0000_0100 at cycle T -> mem_rd at T+1, T+4, T+7, T+10 with mem_addr 0x100..0x103; br_rd_valid at T+13 with br_rd_data=0x5A5B5859.
- br_addr=0xF000_0103 -> mem_addr sequence 0x100..0x103 (high bits and low bits ignored); br_rd_data=0x5A5B5859.
- Second br_rd (0x0000_0200) at T+5 during a read of 0x100 -> first valid at T+13 with 0x5A5B5859, second valid at T+26 with 0x5A5B5859 (0x00..0x03 ^ 0x5A), no IDLE cycle between; overflow=0.
- Three br_rd at T, T+2, T+3 -> the request at T+3 is dropped, overflow=1 from T+4, exactly two br_rd_valid pulses.
- reset=1 at T+6 of an active read -> next cycle busy=0, mem_rd=0, overflow=0; no br_rd_valid within the following 20 cycles.
- RD_LATENCY=1 instance, br_addr=0x10 -> br_rd_valid at T+9 with 0x4A4B4849 (0x10..0x13 ^ 0x5A).
